// File: rtl/exit_gate_fsm_if.sv
// Exit gate controller bus: sensor/pay-terminal inputs, gate/alarm/occupancy outputs.
//   master : environment side (drives sensors, code, car_in; observes outputs)
//   slave  : controller side (observes inputs; drives gate, alarm and occupancy outputs)
interface exit_gate_fsm_if #(
  parameter int unsigned OCC_W = 6
) ();
  logic             senr_e;     // car present at exit approach
  logic             senr_x;     // car has crossed exit gate
  logic [7:0]       code;       // exit code from pay terminal
  logic             code_vld;   // one-cycle strobe, code valid
  logic             car_in;     // one-cycle pulse from entry gate
  logic             gate_o;     // open exit gate
  logic             gate_cls;   // close exit gate
  logic             alm_code;   // bad-code alarm
  logic             alm_blkg;   // tailgate/blocking alarm
  logic [OCC_W-1:0] occupancy;  // cars currently in lot
  logic             full;       // occupancy == CAPACITY
  logic             empty;      // occupancy == 0

  modport master (
    output senr_e, senr_x, code, code_vld, car_in,
    input  gate_o, gate_cls, alm_code, alm_blkg, occupancy, full, empty
  );

  modport slave (
    input  senr_e, senr_x, code, code_vld, car_in,
    output gate_o, gate_cls, alm_code, alm_blkg, occupancy, full, empty
  );
endinterface

// File: rtl/exit_gate_fsm.sv
// Exit-side parking gate controller: validates exit codes, opens/closes the
// exit gate, raises bad-code and tailgate alarms, tracks lot occupancy.
// Ports:
//   clock_i : clock, all logic on posedge
//   reset_i : synchronous active-high reset
//   bus     : exit_gate_fsm_if.slave (sensors, code, car_in in; gate/alarms/occupancy out)
module exit_gate_fsm #(
  parameter logic [7:0]  EXIT_CODE = 8'd185,
  parameter int unsigned MAX_TRIES = 3,
  parameter int unsigned TIMEOUT   = 16,
  parameter int unsigned CAPACITY  = 32,
  parameter int unsigned OCC_W     = 6
) (
  input logic             clock_i,
  input logic             reset_i,
  exit_gate_fsm_if.slave  bus
);

  localparam int unsigned TMR_W = $clog2(TIMEOUT);
  localparam int unsigned FC_W  = 2;

  typedef enum logic [2:0] {
    IDLE          = 3'd0,
    WAIT_CODE     = 3'd1,
    BAD_CODE      = 3'd2,
    CODE_ALARM    = 3'd3,
    CAR_EXITING   = 3'd4,
    GATE_BLOCKING = 3'd5,
    GATE_CLOSING  = 3'd6
  } state_e;

  state_e           state_q, state_d;
  logic [FC_W-1:0]  fail_q, fail_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic             full_q, empty_q;
  logic             gate_o_q, gate_cls_q, alm_code_q, alm_blkg_q;

  logic             code_ok_c, code_bad_c, dec_c, timer_end_c;
  logic [FC_W-1:0]  fail_inc_c;

  assign code_ok_c   = bus.code_vld && (bus.code == EXIT_CODE);
  assign code_bad_c  = bus.code_vld && (bus.code != EXIT_CODE);
  assign timer_end_c = (timer_q == TMR_W'(TIMEOUT - 1));
  // Failure count saturates at MAX_TRIES.
  assign fail_inc_c  = (fail_q == FC_W'(MAX_TRIES)) ? fail_q : fail_q + FC_W'(1);

  // Next-state, counters and exit-decrement decode.
  always_comb begin
    state_d = state_q;
    fail_d  = fail_q;
    timer_d = timer_q;
    dec_c   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.senr_e && !empty_q) begin
          state_d = WAIT_CODE;
          timer_d = '0;
        end
      end
      WAIT_CODE, BAD_CODE: begin
        if (code_ok_c) begin
          state_d = CAR_EXITING;
          fail_d  = '0;
          timer_d = '0;
        end else if (code_bad_c) begin
          fail_d  = fail_inc_c;
          state_d = (fail_inc_c == FC_W'(MAX_TRIES)) ? CODE_ALARM : BAD_CODE;
        end else if (state_q == WAIT_CODE) begin
          // Abandon only while nobody is waiting at the approach.
          if (bus.senr_e) begin
            timer_d = '0;
          end else if (timer_end_c) begin
            state_d = IDLE;
            fail_d  = '0;
            timer_d = '0;
          end else begin
            timer_d = timer_q + TMR_W'(1);
          end
        end
      end
      CODE_ALARM: begin
        if (code_ok_c) begin
          state_d = CAR_EXITING;
          fail_d  = '0;
          timer_d = '0;
        end
      end
      CAR_EXITING: begin
        // Crossing wins over the back-out timeout in the same cycle.
        if (bus.senr_x) begin
          dec_c   = 1'b1;
          state_d = bus.senr_e ? GATE_BLOCKING : GATE_CLOSING;
        end else if (timer_end_c) begin
          state_d = GATE_CLOSING;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      GATE_BLOCKING: begin
        if (code_ok_c) state_d = GATE_CLOSING;
      end
      GATE_CLOSING: state_d = IDLE;
      default:      state_d = IDLE;
    endcase
  end

  // Occupancy next value; simultaneous entry and exit cancel.
  always_comb begin
    occ_d = occ_q;
    case ({bus.car_in, dec_c})
      2'b10:   if (occ_q != OCC_W'(CAPACITY)) occ_d = occ_q + OCC_W'(1);
      2'b01:   if (occ_q != '0)               occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase
  end

  // State, counters and registered Moore outputs decoded from the next state.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      fail_q     <= '0;
      timer_q    <= '0;
      occ_q      <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      gate_o_q   <= 1'b0;
      gate_cls_q <= 1'b0;
      alm_code_q <= 1'b0;
      alm_blkg_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      fail_q     <= fail_d;
      timer_q    <= timer_d;
      occ_q      <= occ_d;
      full_q     <= (occ_d == OCC_W'(CAPACITY));
      empty_q    <= (occ_d == '0);
      gate_o_q   <= (state_d == CAR_EXITING) || (state_d == GATE_BLOCKING);
      gate_cls_q <= (state_d == GATE_CLOSING);
      alm_code_q <= (state_d == CODE_ALARM);
      alm_blkg_q <= (state_d == GATE_BLOCKING);
    end
  end

  assign bus.gate_o    = gate_o_q;
  assign bus.gate_cls  = gate_cls_q;
  assign bus.alm_code  = alm_code_q;
  assign bus.alm_blkg  = alm_blkg_q;
  assign bus.occupancy = occ_q;
  assign bus.full      = full_q;
  assign bus.empty     = empty_q;

endmodule

// File: tb/tb_exit_gate_fsm.sv
// Directed self-checking bench for exit_gate_fsm.
module tb_exit_gate_fsm;

  localparam int unsigned OCC_W = 6;

  logic clock;
  logic reset;
  int   tests;
  int   fails;

  exit_gate_fsm_if #(.OCC_W(OCC_W)) bus ();

  exit_gate_fsm #(
    .EXIT_CODE (8'd185),
    .MAX_TRIES (3),
    .TIMEOUT   (16),
    .CAPACITY  (32),
    .OCC_W     (OCC_W)
  ) dut (
    .clock_i (clock),
    .reset_i (reset),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one edge; outputs are sampled 1ns after it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic cars_in(input int n);
    for (int i = 0; i < n; i++) begin
      bus.car_in = 1'b1;
      tick();
    end
    bus.car_in = 1'b0;
  endtask

  task automatic send_code(input logic [7:0] c);
    bus.code     = c;
    bus.code_vld = 1'b1;
    tick();
    bus.code_vld = 1'b0;
  endtask

  task automatic approach();
    bus.senr_e = 1'b1;
    tick();
    bus.senr_e = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if ({bus.gate_o, bus.gate_cls, bus.alm_code, bus.alm_blkg} !== 4'b0000) begin
      fails++; $display("FAIL reset_outputs: got %b expected 0000",
                        {bus.gate_o, bus.gate_cls, bus.alm_code, bus.alm_blkg});
    end
    tests++;
    if (bus.occupancy !== 6'd0 || bus.empty !== 1'b1 || bus.full !== 1'b0) begin
      fails++; $display("FAIL reset_occ: got occ=%0d empty=%b full=%b expected 0/1/0",
                        bus.occupancy, bus.empty, bus.full);
    end
  endtask

  task automatic test_normal_exit();
    do_reset();
    cars_in(2);
    tests++;
    if (bus.occupancy !== 6'd2 || bus.empty !== 1'b0) begin
      fails++; $display("FAIL normal_occ_in: got %0d/%b expected 2/0", bus.occupancy, bus.empty);
    end
    approach();
    send_code(8'd185);
    tests++;
    if (bus.gate_o !== 1'b1) begin
      fails++; $display("FAIL normal_gate_open: got %b expected 1", bus.gate_o);
    end
    tick();
    tick();
    bus.senr_x = 1'b1;
    tick();
    bus.senr_x = 1'b0;
    tests++;
    if (bus.gate_cls !== 1'b1 || bus.gate_o !== 1'b0 || bus.occupancy !== 6'd1) begin
      fails++; $display("FAIL normal_close: got cls=%b open=%b occ=%0d expected 1/0/1",
                        bus.gate_cls, bus.gate_o, bus.occupancy);
    end
    tick();
    tests++;
    if (bus.gate_cls !== 1'b0 || bus.gate_o !== 1'b0 || bus.occupancy !== 6'd1) begin
      fails++; $display("FAIL normal_idle: got cls=%b open=%b occ=%0d expected 0/0/1",
                        bus.gate_cls, bus.gate_o, bus.occupancy);
    end
  endtask

  task automatic test_bad_code_alarm();
    do_reset();
    cars_in(1);
    approach();
    send_code(8'd10);
    send_code(8'd20);
    tests++;
    if (bus.alm_code !== 1'b0) begin
      fails++; $display("FAIL alarm_early: got %b expected 0", bus.alm_code);
    end
    send_code(8'd30);
    tests++;
    if (bus.alm_code !== 1'b1 || bus.gate_o !== 1'b0) begin
      fails++; $display("FAIL alarm_third: got alm=%b open=%b expected 1/0", bus.alm_code, bus.gate_o);
    end
    send_code(8'd40);
    tests++;
    if (bus.alm_code !== 1'b1) begin
      fails++; $display("FAIL alarm_hold: got %b expected 1", bus.alm_code);
    end
    send_code(8'd185);
    tests++;
    if (bus.alm_code !== 1'b0 || bus.gate_o !== 1'b1) begin
      fails++; $display("FAIL alarm_clear: got alm=%b open=%b expected 0/1", bus.alm_code, bus.gate_o);
    end
    bus.senr_x = 1'b1;
    tick();
    bus.senr_x = 1'b0;
    tick();
    // Failure count must be cleared: a single bad code must not alarm.
    cars_in(1);
    approach();
    send_code(8'd11);
    tests++;
    if (bus.alm_code !== 1'b0 || bus.gate_o !== 1'b0) begin
      fails++; $display("FAIL alarm_failcnt_cleared: got alm=%b open=%b expected 0/0",
                        bus.alm_code, bus.gate_o);
    end
    send_code(8'd185);
    tests++;
    if (bus.gate_o !== 1'b1) begin
      fails++; $display("FAIL alarm_retry_open: got %b expected 1", bus.gate_o);
    end
  endtask

  task automatic test_tailgate();
    do_reset();
    cars_in(2);
    approach();
    send_code(8'd185);
    bus.senr_e = 1'b1;
    bus.senr_x = 1'b1;
    tick();
    bus.senr_e = 1'b0;
    bus.senr_x = 1'b0;
    tests++;
    if (bus.alm_blkg !== 1'b1 || bus.gate_o !== 1'b1 || bus.occupancy !== 6'd1) begin
      fails++; $display("FAIL tailgate_alarm: got blk=%b open=%b occ=%0d expected 1/1/1",
                        bus.alm_blkg, bus.gate_o, bus.occupancy);
    end
    tick();
    send_code(8'd40);
    tests++;
    if (bus.alm_blkg !== 1'b1 || bus.gate_o !== 1'b1 || bus.occupancy !== 6'd1) begin
      fails++; $display("FAIL tailgate_hold: got blk=%b open=%b occ=%0d expected 1/1/1",
                        bus.alm_blkg, bus.gate_o, bus.occupancy);
    end
    send_code(8'd185);
    tests++;
    if (bus.gate_cls !== 1'b1 || bus.alm_blkg !== 1'b0 || bus.gate_o !== 1'b0 ||
        bus.occupancy !== 6'd1) begin
      fails++; $display("FAIL tailgate_close: got cls=%b blk=%b open=%b occ=%0d expected 1/0/0/1",
                        bus.gate_cls, bus.alm_blkg, bus.gate_o, bus.occupancy);
    end
    tick();
    tests++;
    if (bus.gate_cls !== 1'b0 || bus.occupancy !== 6'd1) begin
      fails++; $display("FAIL tailgate_idle: got cls=%b occ=%0d expected 0/1",
                        bus.gate_cls, bus.occupancy);
    end
  endtask

  task automatic test_backout_timeout();
    int  open_cycles;
    logic seen_cls;
    do_reset();
    cars_in(1);
    approach();
    send_code(8'd185);
    open_cycles = 0;
    seen_cls    = 1'b0;
    for (int i = 0; i < 40 && !seen_cls; i++) begin
      if (bus.gate_cls === 1'b1) seen_cls = 1'b1;
      else begin
        if (bus.gate_o === 1'b1) open_cycles++;
        tick();
      end
    end
    tests++;
    if (!seen_cls || open_cycles != 16) begin
      fails++; $display("FAIL backout_timing: got seen_cls=%b open_cycles=%0d expected 1/16",
                        seen_cls, open_cycles);
    end
    tests++;
    if (bus.occupancy !== 6'd1) begin
      fails++; $display("FAIL backout_occ: got %0d expected 1", bus.occupancy);
    end
  endtask

  task automatic test_wait_timeout();
    do_reset();
    cars_in(2);
    // Code on the last cycle before the wait expires is still accepted.
    approach();
    repeat (15) tick();
    send_code(8'd185);
    tests++;
    if (bus.gate_o !== 1'b1) begin
      fails++; $display("FAIL wait_last_cycle: got %b expected 1", bus.gate_o);
    end
    bus.senr_x = 1'b1;
    tick();
    bus.senr_x = 1'b0;
    tick();
    // One cycle later the wait has been abandoned.
    approach();
    repeat (16) tick();
    send_code(8'd185);
    tests++;
    if (bus.gate_o !== 1'b0 || bus.occupancy !== 6'd1) begin
      fails++; $display("FAIL wait_expired: got open=%b occ=%0d expected 0/1",
                        bus.gate_o, bus.occupancy);
    end
  endtask

  task automatic test_occupancy_edges();
    do_reset();
    cars_in(32);
    tests++;
    if (bus.occupancy !== 6'd32 || bus.full !== 1'b1) begin
      fails++; $display("FAIL occ_full: got %0d/%b expected 32/1", bus.occupancy, bus.full);
    end
    cars_in(1);
    tests++;
    if (bus.occupancy !== 6'd32 || bus.full !== 1'b1) begin
      fails++; $display("FAIL occ_saturate: got %0d/%b expected 32/1", bus.occupancy, bus.full);
    end
    approach();
    send_code(8'd185);
    bus.senr_x = 1'b1;
    bus.car_in = 1'b1;
    tick();
    bus.senr_x = 1'b0;
    bus.car_in = 1'b0;
    tests++;
    if (bus.gate_cls !== 1'b1 || bus.occupancy !== 6'd32 || bus.full !== 1'b1) begin
      fails++; $display("FAIL occ_cancel: got cls=%b occ=%0d full=%b expected 1/32/1",
                        bus.gate_cls, bus.occupancy, bus.full);
    end
    do_reset();
    bus.senr_e = 1'b1;
    tick();
    tick();
    send_code(8'd185);
    bus.senr_e = 1'b0;
    tests++;
    if (bus.gate_o !== 1'b0 || bus.empty !== 1'b1) begin
      fails++; $display("FAIL occ_empty_idle: got open=%b empty=%b expected 0/1",
                        bus.gate_o, bus.empty);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    cars_in(3);
    approach();
    send_code(8'd185);
    tests++;
    if (bus.gate_o !== 1'b1) begin
      fails++; $display("FAIL midreset_pre_open: got %b expected 1", bus.gate_o);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tests++;
    if ({bus.gate_o, bus.gate_cls, bus.alm_code, bus.alm_blkg} !== 4'b0000 ||
        bus.occupancy !== 6'd0 || bus.empty !== 1'b1) begin
      fails++; $display("FAIL midreset_state: got outs=%b occ=%0d empty=%b expected 0000/0/1",
                        {bus.gate_o, bus.gate_cls, bus.alm_code, bus.alm_blkg},
                        bus.occupancy, bus.empty);
    end
  endtask

  initial begin
    tests        = 0;
    fails        = 0;
    reset        = 1'b1;
    bus.senr_e   = 1'b0;
    bus.senr_x   = 1'b0;
    bus.code     = 8'd0;
    bus.code_vld = 1'b0;
    bus.car_in   = 1'b0;
    test_reset();
    test_normal_exit();
    test_bad_code_alarm();
    test_tailgate();
    test_backout_timeout();
    test_wait_timeout();
    test_occupancy_edges();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/exit_gate_fsm.md
Name: exit_gate_fsm

Overview:
Exit-side gate controller for the parking lot. It is the outbound counterpart of the entry gate controller.
- Validates an exit (payment) code presented with a valid strobe, then opens the exit gate and closes it once the car has passed.
- Raises alarms on repeated bad codes and on tailgating.
- Maintains the lot occupancy count: incremented by the entry side's car-in pulse, decremented on each completed exit.

Parameters:
EXIT_CODE, 8'd185, code that authorises exit
MAX_TRIES, 3, wrong codes before alarm (1..3)
TIMEOUT, 16, cycles in WAIT_CODE/CAR_EXITING before abandon (>=2)
CAPACITY, 32, maximum cars in lot
OCC_W, 6, occupancy width; CAPACITY <= 2**OCC_W-1

Ports:
clock  in  1  single clock, all logic on posedge
reset  in  1  synchronous, active-high
senr_e  in  1  car present at exit approach
senr_x  in  1  car has crossed exit gate
code  in  8  exit code from pay terminal
code_vld  in  1  one-cycle strobe, code valid
car_in  in  1  one-cycle pulse from entry gate on completed entry
gate_o  out  1  open exit gate
gate_cls  out  1  close exit gate
alm_code  out  1  bad-code alarm
alm_blkg  out  1  tailgate/blocking alarm
occupancy  out  OCC_W  cars currently in lot
full  out  1  occupancy == CAPACITY
empty  out  1  occupancy == 0

Behaviour:
- Reset (sampled at posedge): state IDLE, fail_cnt=0, timer=0, occupancy=0. Outputs after reset: gate_o=0, gate_cls=0, alm_code=0, alm_blkg=0, full=0, empty=1. Reset has priority over all inputs in any state, including mid-exit (gate_o drops next cycle).
- Moore outputs, decoded from registered state:
  - gate_o = CAR_EXITING | GATE_BLOCKING
  - gate_cls = GATE_CLOSING
  - alm_code = CODE_ALARM
  - alm_blkg = GATE_BLOCKING
- Latency: an input sampled at edge N changes state at edge N, so the output is visible in cycle N+1.
- Code acceptance: only cycles with code_vld=1 are evaluated; code is ignored otherwise.
- IDLE: senr_e & !empty -> WAIT_CODE, timer cleared. senr_e while empty: stay IDLE.
- WAIT_CODE, on code_vld:
  - correct code -> CAR_EXITING
  - wrong code -> fail_cnt+1; if the new fail_cnt == MAX_TRIES -> CODE_ALARM, else BAD_CODE
  - no code_vld for TIMEOUT cycles with senr_e=0 -> IDLE, fail_cnt cleared
- BAD_CODE: same code rules as WAIT_CODE (no timeout); waits indefinitely for a retry.
- CODE_ALARM: wrong codes ignored and fail_cnt held; correct code -> CAR_EXITING.
- CAR_EXITING:
  - On entry: fail_cnt cleared, timer cleared. Timer increments each cycle.
  - senr_e & senr_x -> GATE_BLOCKING
  - senr_x only -> GATE_CLOSING
  - timer reaches TIMEOUT-1 with senr_x=0 -> GATE_CLOSING (car backed out, no decrement)
  - senr_x has priority over timeout in the same cycle.
- GATE_BLOCKING: gate held open; correct code -> GATE_CLOSING; all else holds.
- GATE_CLOSING: lasts one cycle, then IDLE.
- Illegal or unused state encodings -> IDLE.
- Decrement rule: exactly one decrement per exit episode, on the CAR_EXITING edge that leaves because senr_x=1 (also covers the path into GATE_BLOCKING). No decrement on leaving GATE_BLOCKING.
- Occupancy update:
  - car_in and decrement in the same cycle: occupancy unchanged
  - car_in alone: +1, saturating at CAPACITY
  - decrement alone: -1, saturating at 0
- full and empty are registered alongside occupancy and consistent with it in the same cycle.
- fail_cnt is 2 bits and saturates at MAX_TRIES.

Test Plan:
- Normal exit:
  - Stimulus: reset; 2 car_in pulses (occupancy=2); senr_e=1; code_vld with code=185 one cycle later; senr_x=1 three cycles later.
  - Response: gate_o=1 the cycle after the code; gate_cls=1 for exactly one cycle; occupancy=1; return to IDLE.
- Bad-code alarm:
  - Stimulus: occupancy=1; codes 10, 20, 30 with code_vld.
  - Response: alm_code=1 the cycle after the third code, gate_o=0. A further code 40 keeps the alarm. Code 185 then gives alm_code=0 and gate_o=1; fail_cnt is 0 after the following exit.
- Tailgate:
  - Stimulus: in CAR_EXITING, senr_e=1 and senr_x=1 in the same cycle.
  - Response: alm_blkg=1, gate_o=1, occupancy decremented once. Code 185 gives gate_cls=1 then IDLE with no second decrement.
- Back-out timeout:
  - Stimulus: TIMEOUT=16; correct code, then no senr_x.
  - Response: gate_cls=1 in the 17th cycle after gate_o rises; occupancy unchanged.
- Occupancy edges:
  - 33 car_in pulses give occupancy=32, full=1.
  - car_in coinciding with a senr_x exit leaves occupancy unchanged.
  - At occupancy=0, senr_e stays IDLE (gate_o=0).
- Reset mid-operation:
  - Stimulus: reset asserted while gate_o=1 in CAR_EXITING.
  - Response: next cycle all alarm/gate outputs 0, occupancy=0, empty=1.
